// File: rtl/pingpong_scratchpad.sv
// rtl/pingpong_scratchpad.sv - rotating multi-buffer scratchpad with compute and DMA ports
// The compute port owns buffer cmp_buf, the DMA port owns the next one; swap_req rotates ownership.

module pingpong_scratchpad #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_BUFS   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      cmp_req,
    input  logic                      cmp_we,
    input  logic [ADDR_WIDTH-1:0]     cmp_addr,
    input  logic [DATA_WIDTH-1:0]     cmp_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmp_be,
    output logic                      cmp_ready,
    output logic                      cmp_rvalid,
    output logic [DATA_WIDTH-1:0]     cmp_rdata,

    input  logic                      dma_req,
    input  logic                      dma_we,
    input  logic [ADDR_WIDTH-1:0]     dma_addr,
    input  logic [DATA_WIDTH-1:0]     dma_wdata,
    input  logic [DATA_WIDTH/8-1:0]   dma_be,
    output logic                      dma_ready,
    output logic                      dma_rvalid,
    output logic [DATA_WIDTH-1:0]     dma_rdata,

    input  logic                      swap_req,
    output logic                      swap_ack,

    output logic [1:0]                cmp_buf,
    output logic [1:0]                dma_buf,
    output logic [15:0]               swap_count
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWAP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          cmp_buf_q;
    logic [1:0]          dma_buf_q;
    logic [15:0]         swap_count_q;
    logic                active;
    logic                cmp_acc;
    logic                dma_acc;
    logic [DATA_WIDTH-1:0] bank_cmp_word [NUM_BUFS];
    logic [DATA_WIDTH-1:0] bank_dma_word [NUM_BUFS];
    logic [DATA_WIDTH-1:0] cmp_word;
    logic [DATA_WIDTH-1:0] dma_word;

    function automatic logic [1:0] buf_inc(input logic [1:0] b);
        return (b == 2'(NUM_BUFS - 1)) ? 2'd0 : b + 2'd1;
    endfunction

    assign active     = (state == ST_ACTIVE);
    assign cmp_ready  = active;
    assign dma_ready  = active;
    assign cmp_acc    = cmp_req & active;
    assign dma_acc    = dma_req & active;
    assign swap_ack   = (state == ST_SWAP);
    assign cmp_buf    = cmp_buf_q;
    assign dma_buf    = dma_buf_q;
    assign swap_count = swap_count_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACTIVE: if (swap_req) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_SWAP;
            ST_SWAP:   state_nxt = ST_ACTIVE;
            default:   state_nxt = ST_ACTIVE;
        endcase
    end

    // Ownership moves only when leaving SWAP, so DRAIN still returns reads under the old mapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ACTIVE;
            cmp_buf_q    <= 2'd0;
            dma_buf_q    <= 2'd1;
            swap_count_q <= 16'd0;
            cmp_rvalid   <= 1'b0;
            dma_rvalid   <= 1'b0;
            cmp_rdata    <= '0;
            dma_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_SWAP) begin
                cmp_buf_q    <= buf_inc(cmp_buf_q);
                dma_buf_q    <= buf_inc(dma_buf_q);
                swap_count_q <= swap_count_q + 16'd1;
            end
            cmp_rvalid <= cmp_acc & ~cmp_we;
            dma_rvalid <= dma_acc & ~dma_we;
            if (cmp_acc && !cmp_we) cmp_rdata <= cmp_word;
            if (dma_acc && !dma_we) dma_rdata <= dma_word;
        end
    end

    always_comb begin
        cmp_word = '0;
        dma_word = '0;
        for (int g = 0; g < NUM_BUFS; g++) begin
            if (cmp_buf_q == 2'(g)) cmp_word = bank_cmp_word[g];
            if (dma_buf_q == 2'(g)) dma_word = bank_dma_word[g];
        end
    end

    // Each bank is written by at most one port at a time because the two owned indices always differ.
    for (genvar g = 0; g < NUM_BUFS; g++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic                  cmp_wr;
        logic                  dma_wr;

        assign cmp_wr = cmp_acc & cmp_we & (cmp_buf_q == 2'(g));
        assign dma_wr = dma_acc & dma_we & (dma_buf_q == 2'(g));

        always_ff @(posedge clk) begin
            for (int b = 0; b < NB; b++) begin
                if (cmp_wr && cmp_be[b]) mem[cmp_addr][8*b +: 8] <= cmp_wdata[8*b +: 8];
                if (dma_wr && dma_be[b]) mem[dma_addr][8*b +: 8] <= dma_wdata[8*b +: 8];
            end
        end

        assign bank_cmp_word[g] = mem[cmp_addr];
        assign bank_dma_word[g] = mem[dma_addr];
    end

endmodule

// File: tb/tb_pingpong_scratchpad.sv
// tb/tb_pingpong_scratchpad.sv - directed bench with cycle model for pingpong_scratchpad
module tb_pingpong_scratchpad;

    localparam int DW   = 256;
    localparam int AW   = 4;
    localparam int NBUF = 3;
    localparam int NBY  = DW / 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmp_req, cmp_we, dma_req, dma_we, swap_req;
    logic [AW-1:0]  cmp_addr, dma_addr;
    logic [DW-1:0]  cmp_wdata, dma_wdata;
    logic [NBY-1:0] cmp_be, dma_be;
    logic           cmp_ready, cmp_rvalid, dma_ready, dma_rvalid, swap_ack;
    logic [DW-1:0]  cmp_rdata, dma_rdata;
    logic [1:0]     cmp_buf, dma_buf;
    logic [15:0]    swap_count;

    always #5 clk = ~clk;

    pingpong_scratchpad #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BUFS(NBUF)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmp_req(cmp_req), .cmp_we(cmp_we), .cmp_addr(cmp_addr), .cmp_wdata(cmp_wdata),
        .cmp_be(cmp_be), .cmp_ready(cmp_ready), .cmp_rvalid(cmp_rvalid), .cmp_rdata(cmp_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_be(dma_be), .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .swap_req(swap_req), .swap_ack(swap_ack),
        .cmp_buf(cmp_buf), .dma_buf(dma_buf), .swap_count(swap_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: memories as plain arrays, timing from the stamp of the cycle where a swap was sampled.
    logic [DW-1:0] mmem [NBUF][2**AW];
    int            cyc, t_sw, m_cbuf, m_count, m_db;
    bit            m_rdy, m_crv, m_drv;
    logic [DW-1:0] m_crd, m_drd;

    function automatic bit m_ready();
        return !(cyc == t_sw + 1 || cyc == t_sw + 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; t_sw = -10; m_cbuf = 0; m_count = 0;
            m_crv = 0; m_drv = 0; m_crd = '0; m_drd = '0;
        end else begin
            m_rdy = m_ready();
            m_db  = (m_cbuf + 1) % NBUF;
            m_crv = 0;
            m_drv = 0;
            if (m_rdy && cmp_req) begin
                if (cmp_we) begin
                    for (int i = 0; i < NBY; i++)
                        if (cmp_be[i]) mmem[m_cbuf][cmp_addr][8*i +: 8] = cmp_wdata[8*i +: 8];
                end else begin
                    m_crd = mmem[m_cbuf][cmp_addr];
                    m_crv = 1;
                end
            end
            if (m_rdy && dma_req) begin
                if (dma_we) begin
                    for (int i = 0; i < NBY; i++)
                        if (dma_be[i]) mmem[m_db][dma_addr][8*i +: 8] = dma_wdata[8*i +: 8];
                end else begin
                    m_drd = mmem[m_db][dma_addr];
                    m_drv = 1;
                end
            end
            if (m_rdy && swap_req) t_sw = cyc;
            cyc++;
            if (cyc == t_sw + 3) begin
                m_cbuf  = (m_cbuf + 1) % NBUF;
                m_count = (m_count + 1) % 65536;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_cmp_ready", DW'(cmp_ready), DW'(m_ready()));
        chk("m_dma_ready", DW'(dma_ready), DW'(m_ready()));
        chk("m_swap_ack", DW'(swap_ack), DW'(cyc == t_sw + 2));
        chk("m_cmp_buf", DW'(cmp_buf), DW'(m_cbuf));
        chk("m_dma_buf", DW'(dma_buf), DW'((m_cbuf + 1) % NBUF));
        chk("m_swap_count", DW'(swap_count), DW'(m_count));
        chk("m_cmp_rvalid", DW'(cmp_rvalid), DW'(m_crv));
        chk("m_dma_rvalid", DW'(dma_rvalid), DW'(m_drv));
        if (!$isunknown(m_crd)) chk("m_cmp_rdata", cmp_rdata, m_crd);
        if (!$isunknown(m_drd)) chk("m_dma_rdata", dma_rdata, m_drd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cop(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NBY-1:0] be);
        cmp_req = 1; cmp_we = we; cmp_addr = a; cmp_wdata = d; cmp_be = be;
        step();
        cmp_req = 0;
    endtask

    task automatic dop(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NBY-1:0] be);
        dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d; dma_be = be;
        step();
        dma_req = 0;
    endtask

    task automatic do_swap();
        int seen;
        seen = -1;
        swap_req = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (swap_ack) begin
                seen = i;
                break;
            end
        end
        chk("swap_ack_latency", DW'(seen), DW'(2));
        step();
        swap_req = 0;
    endtask

    logic [DW-1:0] a5, d26, d29;
    logic [1:0]    exp_c [5];
    logic [1:0]    exp_d [5];

    initial begin
        a5  = {32{8'hA5}};
        d26 = {32{8'h11}};
        d26[7:0] = 8'hFF;
        d29 = {8{32'hDEADBEEF}};
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        exp_d = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        cmp_req = 0; cmp_we = 0; cmp_addr = '0; cmp_wdata = '0; cmp_be = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_be = '0;
        swap_req = 0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_cmp_buf", DW'(cmp_buf), DW'(exp_c[0]));
        chk("rst_dma_buf", DW'(dma_buf), DW'(exp_d[0]));
        chk("rst_ready", DW'({cmp_ready, dma_ready}), DW'(2'b11));
        chk("rst_count", DW'(swap_count), DW'(0));
        step();

        // DMA fills addr 3, rotate, compute sees it
        dop(1, 4'd3, a5, '1);
        do_swap();
        cmp_req = 1; cmp_we = 0; cmp_addr = 4'd3;
        @(negedge clk);
        chk("r25_rvalid_accept_cycle", DW'(cmp_rvalid), DW'(0));
        chk("r25_cmp_buf", DW'(cmp_buf), DW'(exp_c[1]));
        chk("r25_dma_buf", DW'(dma_buf), DW'(exp_d[1]));
        step();
        cmp_req = 0;
        @(negedge clk);
        chk("r25_rvalid", DW'(cmp_rvalid), DW'(1));
        chk("r25_rdata", cmp_rdata, a5);
        @(negedge clk);
        chk("r25_rvalid_drop", DW'(cmp_rvalid), DW'(0));
        chk("r25_rdata_hold", cmp_rdata, a5);
        step();

        // byte-enable partial write
        dop(1, 4'd7, {32{8'h11}}, '1);
        dop(1, 4'd7, '1, 32'h0000_0001);
        dop(0, 4'd7, '0, '0);
        @(negedge clk);
        chk("r26_rvalid", DW'(dma_rvalid), DW'(1));
        chk("r26_rdata", dma_rdata, d26);
        step();
        dop(1, 4'd7, '1, '0);
        dop(0, 4'd7, '0, '0);
        @(negedge clk);
        chk("be0_noop", dma_rdata, d26);
        step();

        // write then read back-to-back
        cop(1, 4'd5, d29, '1);
        cop(0, 4'd5, '0, '0);
        @(negedge clk);
        chk("r29_rdata", cmp_rdata, d29);
        step();

        // swap while both ports read
        cmp_req = 1; cmp_we = 0; cmp_addr = 4'd5;
        dma_req = 1; dma_we = 0; dma_addr = 4'd7;
        swap_req = 1;
        @(negedge clk);
        chk("r27_T_ready", DW'({cmp_ready, dma_ready}), DW'(2'b11));
        step();
        cmp_req = 0; dma_req = 0;
        @(negedge clk);
        chk("r27_T1_rvalid", DW'({cmp_rvalid, dma_rvalid}), DW'(2'b11));
        chk("r27_T1_cmp_rdata", cmp_rdata, d29);
        chk("r27_T1_dma_rdata", dma_rdata, d26);
        chk("r27_T1_ready", DW'({cmp_ready, dma_ready}), DW'(2'b00));
        chk("r27_T1_ack", DW'(swap_ack), DW'(0));
        @(negedge clk);
        chk("r27_T2_ready", DW'({cmp_ready, dma_ready}), DW'(2'b00));
        chk("r27_T2_ack", DW'(swap_ack), DW'(1));
        step();
        swap_req = 0;
        @(negedge clk);
        chk("r27_T3_ready", DW'({cmp_ready, dma_ready}), DW'(2'b11));
        chk("r27_T3_ack", DW'(swap_ack), DW'(0));
        chk("r28_cmp_buf2", DW'(cmp_buf), DW'(exp_c[2]));
        chk("r28_dma_buf2", DW'(dma_buf), DW'(exp_d[2]));
        step();

        for (int k = 3; k < 5; k++) begin
            do_swap();
            @(negedge clk);
            chk("r28_cmp_buf", DW'(cmp_buf), DW'(exp_c[k]));
            chk("r28_dma_buf", DW'(dma_buf), DW'(exp_d[k]));
            step();
        end
        @(negedge clk);
        chk("r28_count", DW'(swap_count), DW'(4));
        step();

        // reset during DRAIN aborts rotation and drops rvalid
        cmp_req = 1; cmp_we = 0; cmp_addr = 4'd5;
        swap_req = 1;
        step();
        cmp_req = 0;
        @(negedge clk);
        chk("r30_drain_rvalid", DW'(cmp_rvalid), DW'(1));
        chk("r30_drain_ready", DW'(cmp_ready), DW'(0));
        #2 rst_n = 0;
        swap_req = 0;
        #1;
        chk("r30_rst_rvalid", DW'(cmp_rvalid), DW'(0));
        chk("r30_rst_rdata", cmp_rdata, '0);
        chk("r30_rst_ack", DW'(swap_ack), DW'(0));
        chk("r30_rst_cmp_buf", DW'(cmp_buf), DW'(0));
        @(negedge clk);
        chk("r30_rst_ack2", DW'(swap_ack), DW'(0));
        step();
        rst_n = 1;
        @(negedge clk);
        chk("r30_ready", DW'({cmp_ready, dma_ready}), DW'(2'b11));
        chk("r30_cmp_buf", DW'(cmp_buf), DW'(0));
        chk("r30_dma_buf", DW'(dma_buf), DW'(1));
        chk("r30_count", DW'(swap_count), DW'(0));
        chk("r30_rvalid", DW'(cmp_rvalid), DW'(0));
        chk("r30_ack", DW'(swap_ack), DW'(0));
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
